bin2bcd_conv: RTL and testbench

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display path. It converts a 14-bit binary count (0–9999) into four packed BCD digits using shift-and-add-3 (double dabble), one bit per clock. Its `bcd` output drives the display's 16-bit digit input in place of raw switches, so the display shows decimal instead of hex. It uses a start/done handshake, fixed latency, and a held result register.

---
 rtl/bin2bcd_conv_pkg.sv | 18 +
 rtl/bin2bcd_conv_bcd_adj3.sv | 10 +
 rtl/bin2bcd_conv.sv | 112 +++++++++++
 tb/tb_bin2bcd_conv.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_conv_pkg.sv
// Shared constants and state encoding for the binary-to-BCD converter.
// Default widths suit a four-digit decimal display fed from a 14-bit count.
package bin2bcd_conv_pkg;

  localparam int BIN_W_DEF  = 14;
  localparam int DIGITS_DEF = 4;

  // Largest value that fits in four decimal digits; above it the result saturates.
  localparam int          BCD_MAX = 9999;
  localparam logic [15:0] SAT_BCD = 16'h9999;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bin2bcd_conv_bcd_adj3.sv
// Single-digit double-dabble corrector: adds 3 to a digit of 5 or more, purely combinational.
// A corrected digit stays within 4 bits, so the carry-out is deliberately dropped.
module bcd_adj3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? (d_i + 4'd3) : d_i;

endmodule

// File: rtl/bin2bcd_conv.sv
// Sequential binary-to-BCD converter, one bit per clock; done pulses BIN_W+1 edges after accept.
// No backpressure: start is only honoured in IDLE, and bcd/ovf hold until the next done.
module bin2bcd_conv
  import bin2bcd_conv_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int WORK_W = BCD_W + BIN_W;
  localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);
  localparam logic [BCD_W-1:0] SAT_VAL  = {DIGITS{4'h9}};

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORK_W-1:0]  work_q, work_d;
  logic               ovf_flag_q, ovf_flag_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic [BCD_W-1:0]   scratch_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d_i (work_q[BIN_W + 4*g +: 4]),
      .d_o (scratch_adj[4*g +: 4])
    );
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    ovf_flag_d = ovf_flag_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    busy_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = SHIFT;
          work_d     = {{BCD_W{1'b0}}, bin};
          cnt_d      = '0;
          ovf_flag_d = (int'(bin) > BCD_MAX);
          busy_d     = 1'b1;
        end
      end
      SHIFT: begin
        // Digits are corrected first, then the whole register shifts as one.
        work_d = {scratch_adj, work_q[BIN_W-1:0]} << 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        bcd_d   = ovf_flag_q ? SAT_VAL : work_q[WORK_W-1 -: BCD_W];
        ovf_d   = ovf_flag_q;
        done_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      ovf_flag_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      ovf_flag_q <= ovf_flag_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// Directed bench for bin2bcd_conv: scoreboard of expected results checked on each done pulse,
// plus latency, busy-length, ignore-start, back-to-back and mid-conversion reset checks.
module tb_bin2bcd_conv;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int   total;
  int   bad;
  int   cyc;
  int   done_cnt;
  exp_t sb_q[$];

  bin2bcd_conv dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Decimal model by repeated division, saturating above four digits.
  function automatic exp_t model(input int v);
    exp_t e;
    int   t;
    if (v > 9999) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      t = v;
      for (int i = 0; i < 4; i++) begin
        e.bcd[4*i +: 4] = 4'(t % 10);
        t = t / 10;
      end
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst && done) begin
      exp_t e;
      done_cnt++;
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("bcd", 32'(bcd), 32'(e.bcd));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  // One full conversion from IDLE: measures done latency and busy length.
  task automatic run_conv(input logic [13:0] v, input string tag);
    int lat;
    int busy_cyc;
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    sb_q.push_back(model(int'(v)));
    @(posedge clk);
    #1;
    start    = 1'b0;
    bin      = 14'($urandom_range(0, 16383));
    busy_cyc = busy ? 1 : 0;
    lat      = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cyc++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd15);
    check({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd14);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int   nd;
    int   t_done[3];
    int   dc0;
    total    = 0;
    bad      = 0;
    cyc      = 0;
    done_cnt = 0;
    rst      = 1'b0;
    start    = 1'b0;
    bin      = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd",  32'(bcd),  32'd0);
    check("reset_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_conv(14'd0,     "zero");
    run_conv(14'd1234,  "v1234");
    run_conv(14'd9999,  "v9999");
    run_conv(14'd10,    "v10");
    run_conv(14'd12000, "v12000");
    run_conv(14'd5,     "v5");

    repeat (5) @(posedge clk);
    #1;
    check("hold_bcd", 32'(bcd), 32'h0005);
    check("hold_ovf", 32'(ovf), 32'd0);

    // Start pulse during SHIFT must be ignored.
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd1234;
    sb_q.push_back(model(1234));
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd42;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("ignore_done_count", 32'(done_cnt - dc0), 32'd1);
    check("ignore_bcd", 32'(bcd), 32'h1234);
    check("ignore_busy", 32'(busy), 32'd0);

    // Start held high: back-to-back conversions every 16 cycles.
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd7;
    for (int i = 0; i < 3; i++) sb_q.push_back(model(7));
    nd = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        t_done[nd] = cyc;
        nd++;
        if (nd == 3) begin
          start = 1'b0;
          break;
        end
      end
    end
    check("b2b_done_count", 32'(nd), 32'd3);
    if (nd == 3) begin
      check("b2b_interval1", 32'(t_done[1] - t_done[0]), 32'd16);
      check("b2b_interval2", 32'(t_done[2] - t_done[1]), 32'd16);
    end
    repeat (20) @(posedge clk);

    // Reset in the middle of a conversion aborts it with no done.
    run_conv(14'd1234, "pre_rst");
    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    bin   = 14'd5678;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_bcd",  32'(bcd),  32'd0);
    check("midrst_ovf",  32'(ovf),  32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("postrst_no_done", 32'(done_cnt - dc0), 32'd0);
    check("postrst_bcd", 32'(bcd), 32'd0);
    run_conv(14'd1, "post_rst");

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
